// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared state encoding and payload widths for the AXI write arbiter
package axi_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // AW payload layout: {awaddr, awlen[7:0], awsize[2:0], awburst[1:0]}
  localparam int AW_CTRL_W = 13;
  localparam int AWLEN_LSB = 5;

  function automatic int aw_pld_w(input int aw);
    return aw + AW_CTRL_W;
  endfunction

  // W payload layout: {wdata, wstrb}
  function automatic int w_pld_w(input int dw);
    return dw + dw / 8;
  endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// rtl/axi_rr_arb2.sv - two-way round-robin grant selection
module axi_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt
);

  // both requesting: move away from the previous winner; otherwise take the lone requester
  always_comb begin
    gnt = 1'b0;
    if (req == 2'b11) begin
      gnt = ~last_gnt;
    end else if (req[1]) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-requester AXI write arbiter, grant held for AW+W+B; optional AXI_WR_ARB_WLAST_CHECK_EN
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64,
  localparam int AWP = aw_pld_w(AW),
  localparam int WP  = w_pld_w(DW)
) (
  input  logic           axi_aclk,
  input  logic           rst_n,
  input  logic [2*AWP-1:0] req_aw_pld,
  input  logic [1:0]     req_awvalid,
  output logic [1:0]     req_awready,
  input  logic [2*WP-1:0] req_w_pld,
  input  logic [1:0]     req_wlast,
  input  logic [1:0]     req_wvalid,
  output logic [1:0]     req_wready,
  output logic [3:0]     req_bresp,
  output logic [1:0]     req_bvalid,
  input  logic [1:0]     req_bready,
  output logic [AWP-1:0] m_aw_pld,
  output logic           m_awvalid,
  input  logic           m_awready,
  output logic [WP-1:0]  m_w_pld,
  output logic           m_wlast,
  output logic           m_wvalid,
  input  logic           m_wready,
  input  logic [1:0]     m_bresp,
  input  logic           m_bvalid,
  output logic           m_bready,
  output logic           busy,
`ifdef AXI_WR_ARB_WLAST_CHECK_EN
  output logic           wlast_err,
`endif
  output logic           gnt_id
);

  logic [1:0]     state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           last_gnt_q, last_gnt_d;
  logic [7:0]     beat_rem_q, beat_rem_d;
  logic           arb_gnt;
  logic [AWP-1:0] aw_sel;
  logic [WP-1:0]  w_sel;
  logic           aw_hs, w_hs, b_hs;

  axi_rr_arb2 u_rr (
    .req      (req_awvalid),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt)
  );

  // payload slices of the currently granted requester
  always_comb begin
    aw_sel = gnt_q ? req_aw_pld[2*AWP-1:AWP] : req_aw_pld[AWP-1:0];
    w_sel  = gnt_q ? req_w_pld[2*WP-1:WP]    : req_w_pld[WP-1:0];
  end

  // route only the channel owned by the current phase; everything else stays quiet
  always_comb begin
    m_aw_pld    = '0;
    m_awvalid   = 1'b0;
    m_w_pld     = '0;
    m_wvalid    = 1'b0;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;
    req_awready = '0;
    req_wready  = '0;
    req_bvalid  = '0;
    req_bresp   = '0;
    case (state_q)
      ST_ADDR: begin
        m_aw_pld             = aw_sel;
        m_awvalid            = req_awvalid[gnt_q];
        req_awready[gnt_q]   = m_awready;
      end
      ST_DATA: begin
        m_w_pld              = w_sel;
        m_wvalid             = req_wvalid[gnt_q];
        m_wlast              = (beat_rem_q == 8'd0);
        req_wready[gnt_q]    = m_wready;
      end
      ST_RESP: begin
        m_bready             = req_bready[gnt_q];
        req_bvalid[gnt_q]    = m_bvalid;
        if (gnt_q) begin
          req_bresp[3:2] = m_bresp;
        end else begin
          req_bresp[1:0] = m_bresp;
        end
      end
      default: begin
      end
    endcase
  end

  assign aw_hs  = m_awvalid & m_awready;
  assign w_hs   = m_wvalid & m_wready;
  assign b_hs   = m_bvalid & m_bready;
  assign busy   = (state_q != ST_IDLE);
  assign gnt_id = gnt_q;

  // transaction sequencing: beat_rem counts down from awlen so 256 beats fit in 8 bits
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    beat_rem_d = beat_rem_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_awvalid) begin
          gnt_d   = arb_gnt;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_hs) begin
          beat_rem_d = aw_sel[AWLEN_LSB +: 8];
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (m_wlast) begin
            state_d = ST_RESP;
          end else begin
            beat_rem_d = beat_rem_q - 8'd1;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          last_gnt_d = gnt_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers; last_gnt resets to 1 so requester 0 wins the first contested round
  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      beat_rem_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      beat_rem_q <= beat_rem_d;
    end
  end

`ifdef AXI_WR_ARB_WLAST_CHECK_EN
  logic wlast_err_q, wlast_err_d;

  // sticky flag: requester's wlast disagrees with the internally counted last beat
  always_comb begin
    wlast_err_d = wlast_err_q;
    if (w_hs && (req_wlast[gnt_q] != m_wlast)) begin
      wlast_err_d = 1'b1;
    end
  end

  // error flag register, cleared only by reset
  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      wlast_err_q <= 1'b0;
    end else begin
      wlast_err_q <= wlast_err_d;
    end
  end

  assign wlast_err = wlast_err_q;
`else
  logic unused_req_wlast;
  assign unused_req_wlast = ^req_wlast;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - directed self-checking bench for axi_wr_arbiter; honours AXI_WR_ARB_WLAST_CHECK_EN
module tb_axi_wr_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int AWP = 45;
  localparam int WP  = 72;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2*AWP-1:0] req_aw_pld;
  logic [1:0]     req_awvalid;
  logic [1:0]     req_awready;
  logic [2*WP-1:0] req_w_pld;
  logic [1:0]     req_wlast;
  logic [1:0]     req_wvalid;
  logic [1:0]     req_wready;
  logic [3:0]     req_bresp;
  logic [1:0]     req_bvalid;
  logic [1:0]     req_bready;
  logic [AWP-1:0] m_aw_pld;
  logic           m_awvalid;
  logic           m_awready;
  logic [WP-1:0]  m_w_pld;
  logic           m_wlast;
  logic           m_wvalid;
  logic           m_wready;
  logic [1:0]     m_bresp;
  logic           m_bvalid;
  logic           m_bready;
  logic           busy;
  logic           gnt_id;
`ifdef AXI_WR_ARB_WLAST_CHECK_EN
  logic           wlast_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_wr_arbiter #(.AW(AW), .DW(DW)) dut (
    .axi_aclk    (clk),
    .rst_n       (rst_n),
    .req_aw_pld  (req_aw_pld),
    .req_awvalid (req_awvalid),
    .req_awready (req_awready),
    .req_w_pld   (req_w_pld),
    .req_wlast   (req_wlast),
    .req_wvalid  (req_wvalid),
    .req_wready  (req_wready),
    .req_bresp   (req_bresp),
    .req_bvalid  (req_bvalid),
    .req_bready  (req_bready),
    .m_aw_pld    (m_aw_pld),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_w_pld     (m_w_pld),
    .m_wlast     (m_wlast),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_bresp     (m_bresp),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready),
    .busy        (busy),
`ifdef AXI_WR_ARB_WLAST_CHECK_EN
    .wlast_err   (wlast_err),
`endif
    .gnt_id      (gnt_id)
  );

  function automatic logic [AWP-1:0] mk_aw(input logic [AW-1:0] addr, input logic [7:0] len);
    return {addr, len, 3'b011, 2'b01};
  endfunction

  task automatic clear_inputs;
    req_aw_pld = '0; req_awvalid = '0; req_w_pld = '0; req_wlast = '0; req_wvalid = '0;
    req_bready = '0; m_awready = 1'b1; m_wready = 1'b1; m_bresp = '0; m_bvalid = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drive requester g's AW until the shared handshake happens; returns at the first DATA negedge
  task automatic drive_aw(input int g, input logic [AW-1:0] addr, input logic [7:0] len, output bit ok);
    bit hs = 1'b0;
    req_aw_pld[g*AWP +: AWP] = mk_aw(addr, len);
    req_awvalid[g] = 1'b1;
    m_awready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (m_awvalid && m_awready && (gnt_id == g[0])) hs = 1'b1;
      @(negedge clk);
      if (hs) break;
    end
    req_awvalid[g] = 1'b0;
    ok = hs;
  endtask

  // stream W beats from requester g until a handshake with m_wlast; returns at the first RESP negedge
  task automatic do_wbeats(input int g, input int maxc, input bit toggle, input int wl_at,
                           output int beats, output int lastb, output bit dok);
    beats = 0; lastb = 0; dok = 1'b1;
    req_wvalid[g] = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      m_wready = toggle ? c[0] : 1'b1;
      req_w_pld[g*WP +: WP] = {DW'(g * 1000 + beats + 1), 8'hff};
      req_wlast[g] = ((beats + 1) == wl_at);
      #1;
      if (m_w_pld !== req_w_pld[g*WP +: WP]) dok = 1'b0;
      if (m_wvalid && m_wready) begin
        beats++;
        if (m_wlast) lastb = beats;
      end
      @(negedge clk);
      if (lastb != 0) break;
    end
    req_wvalid[g] = 1'b0;
    req_wlast[g] = 1'b0;
    m_wready = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    req_awvalid = 2'b11; req_wvalid = 2'b11; req_bready = 2'b11; m_bvalid = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt_id); end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({m_awvalid, m_wvalid, m_wlast, m_bready} !== 4'b0000) begin n_fail++; $display("FAIL reset_mvalid: got %b want 0000", {m_awvalid, m_wvalid, m_wlast, m_bready}); end
    n_cmp++; if ({req_awready, req_wready, req_bvalid} !== 6'b0) begin n_fail++; $display("FAIL reset_reqs: got %b want 000000", {req_awready, req_wready, req_bvalid}); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_held: got %b want 0", busy); end
`ifdef AXI_WR_ARB_WLAST_CHECK_EN
    n_cmp++; if (wlast_err !== 1'b0) begin n_fail++; $display("FAIL reset_wlast_err: got %b want 0", wlast_err); end
`endif
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int beats, lastb; bit dok;
    apply_reset();
    @(negedge clk);
    req_aw_pld[AWP-1:0] = mk_aw(32'h0000_1000, 8'd3);
    req_awvalid = 2'b01; req_bready = 2'b11;
    #1;
    n_cmp++; if ({busy, m_awvalid, m_bready} !== 3'b000) begin n_fail++; $display("FAIL single_idle: got %b want 000", {busy, m_awvalid, m_bready}); end
    @(negedge clk); #1;
    n_cmp++; if ({busy, gnt_id, m_awvalid, m_wvalid} !== 4'b1010) begin n_fail++; $display("FAIL single_addr: got %b want 1010", {busy, gnt_id, m_awvalid, m_wvalid}); end
    n_cmp++; if (m_aw_pld !== {32'h0000_1000, 8'd3, 3'b011, 2'b01}) begin n_fail++; $display("FAIL single_awpld: got %h", m_aw_pld); end
    n_cmp++; if (req_awready !== 2'b01) begin n_fail++; $display("FAIL single_awready: got %b want 01", req_awready); end
    @(negedge clk);
    req_awvalid = 2'b00;
    do_wbeats(0, 20, 1'b0, 4, beats, lastb, dok);
    n_cmp++; if (beats !== 4) begin n_fail++; $display("FAIL single_beats: got %0d want 4", beats); end
    n_cmp++; if (lastb !== 4) begin n_fail++; $display("FAIL single_wlast_pos: got %0d want 4", lastb); end
    n_cmp++; if (dok !== 1'b1) begin n_fail++; $display("FAIL single_wpld: got %b want 1", dok); end
    m_bvalid = 1'b1; m_bresp = 2'b10;
    #1;
    n_cmp++; if ({m_bready, req_bvalid, req_bresp} !== 7'b1_01_0010) begin n_fail++; $display("FAIL single_b: got %b want 1010010", {m_bready, req_bvalid, req_bresp}); end
    @(negedge clk);
    m_bvalid = 1'b0;
    #1;
    n_cmp++; if ({busy, req_bvalid} !== 3'b000) begin n_fail++; $display("FAIL single_done: got %b want 000", {busy, req_bvalid}); end
  endtask

  task automatic test_round_robin;
    int beats, lastb; bit dok;
    apply_reset();
    @(negedge clk);
    req_aw_pld = {mk_aw(32'hB000_0000, 8'd1), mk_aw(32'hA000_0000, 8'd0)};
    req_awvalid = 2'b11; req_bready = 2'b11;
    @(negedge clk); #1;
    n_cmp++; if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL rr_first_gnt: got %b want 0", gnt_id); end
    n_cmp++; if (req_awready !== 2'b01) begin n_fail++; $display("FAIL rr_first_awready: got %b want 01", req_awready); end
    n_cmp++; if (m_aw_pld !== {32'hA000_0000, 8'd0, 3'b011, 2'b01}) begin n_fail++; $display("FAIL rr_first_awpld: got %h", m_aw_pld); end
    @(negedge clk);
    req_awvalid = 2'b10;
    #1;
    n_cmp++; if (req_awready !== 2'b00) begin n_fail++; $display("FAIL rr_data_awready: got %b want 00", req_awready); end
    do_wbeats(0, 10, 1'b0, 1, beats, lastb, dok);
    n_cmp++; if (beats !== 1) begin n_fail++; $display("FAIL rr_r0_beats: got %0d want 1", beats); end
    m_bvalid = 1'b1;
    #1;
    n_cmp++; if ({req_bvalid, req_awready} !== 4'b0100) begin n_fail++; $display("FAIL rr_r0_b: got %b want 0100", {req_bvalid, req_awready}); end
    @(negedge clk);
    m_bvalid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if ({gnt_id, req_awready} !== 3'b110) begin n_fail++; $display("FAIL rr_second_gnt: got %b want 110", {gnt_id, req_awready}); end
    n_cmp++; if (m_aw_pld !== {32'hB000_0000, 8'd1, 3'b011, 2'b01}) begin n_fail++; $display("FAIL rr_second_awpld: got %h", m_aw_pld); end
    @(negedge clk);
    req_awvalid = 2'b00;
    do_wbeats(1, 10, 1'b0, 2, beats, lastb, dok);
    n_cmp++; if ({beats[7:0], lastb[7:0]} !== {8'd2, 8'd2}) begin n_fail++; $display("FAIL rr_r1_beats: got %0d/%0d want 2/2", beats, lastb); end
    m_bvalid = 1'b1;
    #1;
    n_cmp++; if (req_bvalid !== 2'b10) begin n_fail++; $display("FAIL rr_r1_b: got %b want 10", req_bvalid); end
    @(negedge clk);
    m_bvalid = 1'b0;
    req_awvalid = 2'b11;
    @(negedge clk); #1;
    n_cmp++; if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL rr_third_gnt: got %b want 0", gnt_id); end
  endtask

  task automatic test_long_burst;
    int beats, lastb; bit dok, ok;
    apply_reset();
    req_bready = 2'b01;
    @(negedge clk);
    drive_aw(0, 32'h0000_8000, 8'd255, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL long_aw: got %b want 1", ok); end
    do_wbeats(0, 700, 1'b1, 256, beats, lastb, dok);
    n_cmp++; if (beats !== 256) begin n_fail++; $display("FAIL long_beats: got %0d want 256", beats); end
    n_cmp++; if (lastb !== 256) begin n_fail++; $display("FAIL long_wlast_pos: got %0d want 256", lastb); end
    n_cmp++; if (dok !== 1'b1) begin n_fail++; $display("FAIL long_wpld: got %b want 1", dok); end
    m_bvalid = 1'b1;
    @(negedge clk);
    m_bvalid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL long_done: got %b want 0", busy); end
  endtask

  task automatic test_b_delay;
    int beats, lastb, bhs; bit dok, ok;
    apply_reset();
    @(negedge clk);
    drive_aw(1, 32'h0000_4000, 8'd0, ok);
    do_wbeats(1, 10, 1'b0, 1, beats, lastb, dok);
    n_cmp++; if ({ok, beats[7:0]} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL bdly_setup: got %b/%0d want 1/1", ok, beats); end
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if ({busy, req_bvalid} !== 3'b100) begin n_fail++; $display("FAIL bdly_wait%0d: got %b want 100", c, {busy, req_bvalid}); end
      @(negedge clk);
    end
    m_bvalid = 1'b1; m_bresp = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if ({busy, m_bready, req_bvalid, req_bresp} !== 8'b1_0_10_0100) begin n_fail++; $display("FAIL bdly_stall%0d: got %b want 10100100", c, {busy, m_bready, req_bvalid, req_bresp}); end
      @(negedge clk);
    end
    req_bready = 2'b10;
    bhs = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (m_bvalid && m_bready) bhs++;
      @(negedge clk);
      m_bvalid = 1'b0;
    end
    n_cmp++; if (bhs !== 1) begin n_fail++; $display("FAIL bdly_bhs: got %0d want 1", bhs); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bdly_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int beats, lastb; bit dok, ok;
    apply_reset();
    req_bready = 2'b11;
    @(negedge clk);
    drive_aw(0, 32'h0000_2000, 8'd7, ok);
    req_wvalid = 2'b01;
    req_w_pld[WP-1:0] = {64'h1111, 8'hff};
    @(negedge clk);
    req_w_pld[WP-1:0] = {64'h2222, 8'hff};
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, gnt_id, m_awvalid, m_wvalid, m_wlast, m_bready} !== 6'b0) begin n_fail++; $display("FAIL rmid_outs: got %b want 000000", {busy, gnt_id, m_awvalid, m_wvalid, m_wlast, m_bready}); end
    n_cmp++; if ({req_wready, m_w_pld} !== {2'b00, 72'h0}) begin n_fail++; $display("FAIL rmid_w: got %b/%h want 00/0", req_wready, m_w_pld); end
    @(negedge clk);
    rst_n = 1'b1;
    req_aw_pld[AWP-1:0] = mk_aw(32'h0000_3000, 8'd2);
    req_awvalid = 2'b01;
    #1;
    n_cmp++; if ({busy, m_wvalid} !== 2'b00) begin n_fail++; $display("FAIL rmid_idle: got %b want 00", {busy, m_wvalid}); end
    @(negedge clk); #1;
    n_cmp++; if ({m_awvalid, m_wvalid, gnt_id} !== 3'b100) begin n_fail++; $display("FAIL rmid_addr: got %b want 100", {m_awvalid, m_wvalid, gnt_id}); end
    @(negedge clk);
    req_awvalid = 2'b00;
    do_wbeats(0, 20, 1'b0, 3, beats, lastb, dok);
    n_cmp++; if ({beats[7:0], lastb[7:0]} !== {8'd3, 8'd3}) begin n_fail++; $display("FAIL rmid_beats: got %0d/%0d want 3/3", beats, lastb); end
    m_bvalid = 1'b1;
    @(negedge clk);
    m_bvalid = 1'b0;
  endtask

`ifdef AXI_WR_ARB_WLAST_CHECK_EN
  task automatic test_wlast_err;
    int beats, lastb; bit dok, ok;
    apply_reset();
    req_bready = 2'b01;
    @(negedge clk);
    drive_aw(0, 32'h0000_5000, 8'd1, ok);
    do_wbeats(0, 10, 1'b0, 1, beats, lastb, dok);
    n_cmp++; if ({beats[7:0], wlast_err} !== {8'd2, 1'b1}) begin n_fail++; $display("FAIL werr_set: got %0d/%b want 2/1", beats, wlast_err); end
    m_bvalid = 1'b1;
    @(negedge clk);
    m_bvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (wlast_err !== 1'b1) begin n_fail++; $display("FAIL werr_sticky: got %b want 1", wlast_err); end
    apply_reset();
    #1;
    n_cmp++; if (wlast_err !== 1'b0) begin n_fail++; $display("FAIL werr_clear: got %b want 0", wlast_err); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_long_burst();
    test_b_delay();
    test_reset_mid();
`ifdef AXI_WR_ARB_WLAST_CHECK_EN
    test_wlast_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
